// File: rtl/debug_frame_tx.sv
// Word-to-byte frame serializer for the debug UART link: header, length, payload words MSB-first, checksum.
// Optional trailing XOR checksum byte is built only when DEBUG_FRAME_TX_CHECKSUM_EN is defined.
module debug_frame_tx #(
  parameter int unsigned SIZE        = 32,
  parameter int unsigned MAX_WORDS   = 64,
  parameter int unsigned ADDR_WIDTH  = $clog2(MAX_WORDS),
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_num_words,
  output logic [ADDR_WIDTH-1:0] o_word_addr,
  input  logic [SIZE-1:0]       i_word_data,
  input  logic                  i_tx_full,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned NBYTES = SIZE / 8;
  localparam int unsigned BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BC_W-1:0]     BC_LAST = BC_W'(NBYTES - 1);
  localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH + 1)'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LEN,
    RD,
    LOAD,
    BYTE,
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
    CHK,
`endif
    FIN
  } state_t;

`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
  localparam state_t TAIL = CHK;
`else
  localparam state_t TAIL = FIN;
`endif

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SIZE-1:0]       shreg_q, shreg_d;
  logic [BC_W-1:0]       bcnt_q, bcnt_d;
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic [7:0]          tx_data;
  logic                push;
  logic [ADDR_WIDTH:0] next_idx;

  assign next_idx = {1'b0, addr_q} + (ADDR_WIDTH + 1)'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      shreg_q <= '0;
      bcnt_q  <= '0;
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    tx_data = '0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          count_d = (i_num_words > MAX_CNT) ? MAX_CNT : i_num_words;
          addr_d  = '0;
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = HDR;
        end
      end
      HDR: begin
        tx_data = HEADER_BYTE;
        if (!i_tx_full) begin
          push    = 1'b1;
          state_d = LEN;
        end
      end
      LEN: begin
        tx_data = 8'(count_q);
        if (!i_tx_full) begin
          push    = 1'b1;
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
          csum_d  = csum_q ^ tx_data;
`endif
          state_d = (count_q == '0) ? TAIL : RD;
        end
      end
      RD:   state_d = LOAD;
      LOAD: begin
        shreg_d = i_word_data;
        bcnt_d  = BC_LAST;
        state_d = BYTE;
      end
      BYTE: begin
        tx_data = shreg_q[SIZE-1 -: 8];
        if (!i_tx_full) begin
          push    = 1'b1;
          shreg_d = shreg_q << 8;
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
          csum_d  = csum_q ^ tx_data;
`endif
          // The word index doubles as the source address; it only advances when another word follows.
          if (bcnt_q != '0) begin
            bcnt_d = bcnt_q - BC_W'(1);
          end else if (next_idx >= count_q) begin
            state_d = TAIL;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = RD;
          end
        end
      end
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
      CHK: begin
        tx_data = csum_q;
        if (!i_tx_full) begin
          push    = 1'b1;
          state_d = FIN;
        end
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are masked by reset so an abort cannot leak a push or done in the reset cycle.
  assign o_tx_start  = push & i_rst;
  assign o_tx_data   = tx_data;
  assign o_done      = (state_q == FIN) & i_rst;
  assign o_busy      = (state_q != IDLE) && (state_q != FIN);
  assign o_word_addr = addr_q;

endmodule

// File: tb/tb_debug_frame_tx.sv
// Self-checking bench for debug_frame_tx: frame vector table with a byte scoreboard plus reset corner sequences.
module tb_debug_frame_tx;

  localparam int unsigned SIZE      = 32;
  localparam int unsigned MAX_WORDS = 64;
  localparam int unsigned AW        = 6;
  localparam int unsigned NONE      = 999;
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
  localparam int unsigned CK_CYC = 1;
`else
  localparam int unsigned CK_CYC = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   num_words;
  logic [AW-1:0] word_addr;
  logic [31:0]   word_data;
  logic          tx_full;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          busy;
  logic          done;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [31:0] mem [MAX_WORDS];
  logic [7:0]  sbq [$];

  debug_frame_tx #(
    .SIZE(SIZE),
    .MAX_WORDS(MAX_WORDS),
    .ADDR_WIDTH(AW),
    .HEADER_BYTE(8'hA5)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .i_start(start),
    .i_num_words(num_words),
    .o_word_addr(word_addr),
    .i_word_data(word_data),
    .i_tx_full(tx_full),
    .o_tx_data(tx_data),
    .o_tx_start(tx_start),
    .o_busy(busy),
    .o_done(done)
  );

  always #5 clk = ~clk;

  // Debug source with one cycle of read latency.
  always @(posedge clk) word_data <= mem[word_addr];

  typedef struct {
    int unsigned num;
    int unsigned stall_idx;
    int unsigned stall_len;
    bit          start_at_done;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input int unsigned n_req, input int unsigned stall_idx,
                           input int unsigned stall_len, input bit start_at_done);
    int unsigned n, exp_lat, pushed, rem;
    logic [7:0]  ck, b, nb;
    bit          done_seen;
    n  = (n_req > MAX_WORDS) ? MAX_WORDS : n_req;
    nb = 8'(n);
    ck = nb;
    sbq.delete();
    sbq.push_back(8'hA5);
    sbq.push_back(nb);
    for (int unsigned w = 0; w < n; w++) begin
      for (int k = 3; k >= 0; k--) begin
        b = mem[w][k*8 +: 8];
        sbq.push_back(b);
        ck ^= b;
      end
    end
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
    sbq.push_back(ck);
`endif
    exp_lat = 2 + n * (2 + SIZE / 8) + CK_CYC + stall_len;

    @(negedge clk);
    num_words = (AW + 1)'(n_req);
    start     = 1'b1;
    #1 check("idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start     = 1'b0;
    num_words = '0;
    pushed    = 0;
    rem       = stall_len;
    done_seen = 1'b0;
    for (int unsigned cyc = 0; cyc < exp_lat + 50 && !done_seen; cyc++) begin
      tx_full = (pushed == stall_idx && rem > 0);
      #1;
      if (cyc == 0) check("busy_after_start", {31'd0, busy}, 32'd1);
      if (tx_full) begin
        check("stall_strobe", {31'd0, tx_start}, 32'd0);
        if (sbq.size() > 0) check("stall_data", {24'd0, tx_data}, {24'd0, sbq[0]});
        rem--;
      end else if (tx_start) begin
        if (sbq.size() == 0) check("extra_push", {24'd0, tx_data}, 32'hFFFF_FFFF);
        else check("byte", {24'd0, tx_data}, {24'd0, sbq.pop_front()});
        pushed++;
      end
      if (done) begin
        done_seen = 1'b1;
        check("latency", cyc, exp_lat);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("bytes_left", sbq.size(), 32'd0);
        check("last_addr", {26'd0, word_addr}, (n == 0) ? 32'd0 : n - 1);
        if (start_at_done) start = 1'b1;
      end
      @(negedge clk);
    end
    tx_full = 1'b0;
    start   = 1'b0;
    if (!done_seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: no o_done within %0d cycles, expected at %0d", exp_lat + 50, exp_lat);
      sbq.delete();
    end
    #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  vec_t vecs [7];
  logic [7:0] pre_rst [4];

  initial begin
    int unsigned pushed;
    bit          hit;
    mem[0] = 32'h1122_3344;
    mem[1] = 32'hDEAD_BEEF;
    for (int unsigned i = 2; i < MAX_WORDS; i++) mem[i] = (i + 1) * 32'h9E37_79B9 ^ (i << 24);

    vecs[0] = '{num: 2,   stall_idx: NONE, stall_len: 0, start_at_done: 1'b0};
    vecs[1] = '{num: 0,   stall_idx: NONE, stall_len: 0, start_at_done: 1'b0};
    vecs[2] = '{num: 2,   stall_idx: 4,    stall_len: 4, start_at_done: 1'b0};
    vecs[3] = '{num: 100, stall_idx: NONE, stall_len: 0, start_at_done: 1'b0};
    vecs[4] = '{num: 3,   stall_idx: 0,    stall_len: 2, start_at_done: 1'b1};
    vecs[5] = '{num: 1,   stall_idx: 1,    stall_len: 3, start_at_done: 1'b0};
    vecs[6] = '{num: 1,   stall_idx: 5,    stall_len: 2, start_at_done: 1'b1};

    rst_n     = 1'b0;
    start     = 1'b1;
    num_words = 7'd5;
    tx_full   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_strobe", {31'd0, tx_start}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_addr", {26'd0, word_addr}, 32'd0);
    end
    rst_n = 1'b1;
    start = 1'b0;

    for (int unsigned v = 0; v < 7; v++)
      run_frame(vecs[v].num, vecs[v].stall_idx, vecs[v].stall_len, vecs[v].start_at_done);

    // Abort while the third payload byte (0x33) is pending.
    pre_rst[0] = 8'hA5; pre_rst[1] = 8'h02; pre_rst[2] = 8'h11; pre_rst[3] = 8'h22;
    @(negedge clk);
    num_words = 7'd2;
    start     = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    pushed = 0;
    hit    = 1'b0;
    for (int unsigned cyc = 0; cyc < 40 && !hit; cyc++) begin
      if (pushed == 4) begin
        rst_n = 1'b0;
        #1 check("abort_strobe", {31'd0, tx_start}, 32'd0);
        hit = 1'b1;
      end else begin
        #1;
        if (tx_start) begin
          check("abort_pre_byte", {24'd0, tx_data}, {24'd0, pre_rst[pushed]});
          pushed++;
        end
        @(negedge clk);
      end
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL abort_reach: pushed %0d bytes, expected 4 before abort", pushed);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      #1;
      check("post_abort_strobe", {31'd0, tx_start}, 32'd0);
      check("post_abort_done", {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    run_frame(2, NONE, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
